esd_input_conditioner: RTL and testbench

Front-end conditioning stage for the emergency-shutdown controller. It synchronises and debounces the raw E-STOP A/B, ACK and watchdog-kick pins. It then emits clean active-high levels and single-cycle event pulses to the shutdown FSM. It also monitors the two E-STOP channels for prolonged disagreement and latches a discrepancy fault, so a single stuck contact forces a shutdown request.

---
 rtl/esd_input_conditioner.sv | 136 +++++++++++++
 tb/tb_esd_input_conditioner.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/esd_input_conditioner.sv
// Input conditioning for the emergency-shutdown controller: synchronise and debounce the E-STOP,
// ACK and kick pins, and latch a fault when the two E-STOP channels disagree for too long.
module esd_input_conditioner #(
    parameter int unsigned PRESS_CYCLES   = 16,
    parameter int unsigned RELEASE_CYCLES = 512,
    parameter int unsigned DISC_CYCLES    = 50000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic estop_a_n_in,
    input  logic estop_b_n_in,
    input  logic ack_n_in,
    input  logic wdg_kick_in,
    output logic estop_a,
    output logic estop_b,
    output logic both_released,
    output logic disc_fault,
    output logic shutdown_req,
    output logic ack_pulse,
    output logic kick_pulse
);

    localparam logic [CNT_W-1:0] PressMax   = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] ReleaseMax = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DiscMax    = CNT_W'(DISC_CYCLES - 1);

    // Bit order for sync and debounce vectors: 0 = E-STOP A, 1 = E-STOP B, 2 = ACK, 3 = kick.
    localparam logic [3:0] SyncRst = 4'b0100;
    localparam logic [2:0] DebRst  = 3'b011;

    typedef enum logic [1:0] {StOk, StDisagree, StFault} disc_state_e;

    logic [3:0]       sync1_q, sync2_q;
    logic             kick_sync3_q;
    logic [2:0]       deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [CNT_W-1:0] thr_max;
    logic [2:0]       pressed_lvl;
    logic             ack_pulse_q, kick_pulse_q;
    disc_state_e      state_q, state_d;
    logic [CNT_W-1:0] disc_cnt_q, disc_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= SyncRst;
            sync2_q      <= SyncRst;
            kick_sync3_q <= 1'b0;
        end else begin
            sync1_q      <= {wdg_kick_in, ack_n_in, estop_b_n_in, estop_a_n_in};
            sync2_q      <= sync1_q;
            kick_sync3_q <= sync2_q[3];
        end
    end

    // Debounced state is held active-high (1 = pressed), so compare against inverted pins.
    assign pressed_lvl = ~sync2_q[2:0];

    always_comb begin
        deb_d   = deb_q;
        thr_max = ReleaseMax;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (pressed_lvl[i] != deb_q[i]) begin
                // Only E-STOP channels use the short threshold, and only towards pressed.
                thr_max = (i != 2 && !deb_q[i]) ? PressMax : ReleaseMax;
                if (cnt_q[i] == thr_max) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q        <= DebRst;
            cnt_q        <= '{default: '0};
            ack_pulse_q  <= 1'b0;
            kick_pulse_q <= 1'b0;
        end else begin
            deb_q        <= deb_d;
            cnt_q        <= cnt_d;
            ack_pulse_q  <= deb_d[2] & ~deb_q[2];
            kick_pulse_q <= sync2_q[3] & ~kick_sync3_q;
        end
    end

    assign estop_a       = deb_q[0];
    assign estop_b       = deb_q[1];
    assign both_released = ~deb_q[0] & ~deb_q[1];
    assign ack_pulse     = ack_pulse_q;
    assign kick_pulse    = kick_pulse_q;
    assign shutdown_req  = deb_q[0] | deb_q[1] | disc_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StOk;
            disc_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            disc_cnt_q <= disc_cnt_d;
        end
    end

    // Threshold is tested before re-agreement so a fault cannot be dodged on the last cycle.
    always_comb begin
        state_d    = state_q;
        disc_cnt_d = '0;
        unique case (state_q)
            StOk: begin
                if (estop_a != estop_b) state_d = StDisagree;
            end
            StDisagree: begin
                if (disc_cnt_q == DiscMax) begin
                    state_d = StFault;
                end else if (estop_a == estop_b) begin
                    state_d = StOk;
                end else begin
                    disc_cnt_d = disc_cnt_q + 1'b1;
                end
            end
            StFault: begin
                if (both_released && ack_pulse_q) state_d = StOk;
            end
            default: state_d = StOk;
        endcase
    end

    always_comb begin
        disc_fault = (state_q == StFault);
    end

endmodule

// File: tb/tb_esd_input_conditioner.sv
// Randomised and directed bench for esd_input_conditioner, checked cycle by cycle against a
// behavioural model built from run lengths of stable input levels.
module tb_esd_input_conditioner;

    localparam int unsigned PRESS = 4;
    localparam int unsigned REL   = 10;
    localparam int unsigned DISC  = 60;
    localparam int unsigned CW    = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_n = 1'b1, b_n = 1'b1, ack_n = 1'b1, kick = 1'b0;
    logic estop_a, estop_b, both_released, disc_fault, shutdown_req, ack_pulse, kick_pulse;
    logic [6:0] dut_vec;

    int checks = 0;
    int failures = 0;
    int n_ack = 0;
    int n_kick = 0;

    // Model state: raw pin history, accepted levels, run lengths of disagreement.
    logic [3:0] m_s1, m_s2;
    logic       m_k3;
    logic [2:0] m_deb;
    int         m_run [3];
    logic       m_ackp, m_kickp;
    int         m_mode;
    int         m_len;

    esd_input_conditioner #(
        .PRESS_CYCLES  (PRESS),
        .RELEASE_CYCLES(REL),
        .DISC_CYCLES   (DISC),
        .CNT_W         (CW)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .estop_a_n_in (a_n),
        .estop_b_n_in (b_n),
        .ack_n_in     (ack_n),
        .wdg_kick_in  (kick),
        .estop_a      (estop_a),
        .estop_b      (estop_b),
        .both_released(both_released),
        .disc_fault   (disc_fault),
        .shutdown_req (shutdown_req),
        .ack_pulse    (ack_pulse),
        .kick_pulse   (kick_pulse)
    );

    always #5 clk = ~clk;

    assign dut_vec = {estop_a, estop_b, both_released, disc_fault, shutdown_req, ack_pulse,
                      kick_pulse};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_s1    = 4'b0100;
        m_s2    = 4'b0100;
        m_k3    = 1'b0;
        m_deb   = 3'b011;
        m_run   = '{0, 0, 0};
        m_ackp  = 1'b0;
        m_kickp = 1'b0;
        m_mode  = 0;
        m_len   = 0;
    endfunction

    // One clock edge of the model; every rule reads pre-edge values.
    function automatic void model_step();
        logic want;
        int   thr;
        case (m_mode)
            0: if (m_deb[0] != m_deb[1]) begin m_mode = 1; m_len = 0; end
            1: begin
                m_len++;
                if (m_len == DISC) m_mode = 2;
                else if (m_deb[0] == m_deb[1]) m_mode = 0;
            end
            default: if (!m_deb[0] && !m_deb[1] && m_ackp) m_mode = 0;
        endcase
        m_kickp = m_s2[3] & ~m_k3;
        m_k3    = m_s2[3];
        m_ackp  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            want = ~m_s2[i];
            if (want == m_deb[i]) begin
                m_run[i] = 0;
            end else begin
                m_run[i]++;
                thr = (i < 2 && !m_deb[i]) ? PRESS : REL;
                if (m_run[i] == thr) begin
                    m_deb[i] = want;
                    m_run[i] = 0;
                    if (i == 2 && want) m_ackp = 1'b1;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = {kick, ack_n, b_n, a_n};
    endfunction

    function automatic logic [6:0] model_vec();
        logic f;
        f = (m_mode == 2);
        return {m_deb[0], m_deb[1], ~m_deb[0] & ~m_deb[1], f, m_deb[0] | m_deb[1] | f, m_ackp,
                m_kickp};
    endfunction

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        @(negedge clk);
        check_eq("outputs", dut_vec, model_vec());
        n_ack  += int'(ack_pulse);
        n_kick += int'(kick_pulse);
    endtask

    task automatic async_reset_check();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_eq("async_reset", dut_vec, 7'b1100100);
    endtask

    initial begin
        int n;
        int base;
        int first;
        int hold [4];

        model_reset();
        repeat (2) @(negedge clk);
        check_eq("reset_values", dut_vec, 7'b1100100);
        rst_n = 1'b1;

        n = 0;
        do begin cycle(); n++; end while (estop_a !== 1'b0 && n < int'(REL) + 10);
        check_eq("idle_release_edges", n, REL + 2);
        check_eq("idle_state", {estop_b, both_released, shutdown_req, disc_fault}, 4'b0100);

        a_n = 1'b0;
        repeat (PRESS - 1) cycle();
        a_n = 1'b1;
        repeat (6) cycle();
        check_eq("glitch_rejected", estop_a, 1'b0);

        a_n = 1'b0;
        n = 0;
        do begin cycle(); n++; end while (estop_a !== 1'b1 && n < 50);
        check_eq("press_edges", n, PRESS + 2);
        check_eq("press_shutdown", shutdown_req, 1'b1);
        a_n = 1'b1;
        n = 0;
        do begin cycle(); n++; end while (estop_a !== 1'b0 && n < int'(REL) + 10);
        check_eq("release_edges", n, REL + 2);

        a_n = 1'b0;
        repeat (DISC + PRESS + 10) cycle();
        check_eq("disc_fault_set", disc_fault, 1'b1);
        base = n_ack;
        ack_n = 1'b0;
        repeat (REL + 5) cycle();
        ack_n = 1'b1;
        repeat (REL + 5) cycle();
        check_eq("ack_while_pressed_pulses", n_ack - base, 1);
        check_eq("fault_held_while_pressed", disc_fault, 1'b1);
        a_n = 1'b1;
        repeat (REL + 5) cycle();
        check_eq("fault_held_until_ack", {both_released, disc_fault}, 2'b11);
        ack_n = 1'b0;
        n = 0;
        do begin cycle(); n++; end while (disc_fault !== 1'b0 && n < int'(REL) + 10);
        check_eq("fault_clear_edges", n, REL + 3);
        ack_n = 1'b1;
        repeat (REL + 5) cycle();

        base = n_ack;
        first = 0;
        ack_n = 1'b0;
        for (int i = 1; i <= 5 * int'(REL); i++) begin
            cycle();
            if (ack_pulse && first == 0) first = i;
        end
        check_eq("ack_hold_pulses", n_ack - base, 1);
        check_eq("ack_pulse_edge", first, REL + 2);
        ack_n = 1'b1;
        repeat (REL + 5) cycle();

        base = n_kick;
        for (int r = 0; r < 3; r++) begin
            kick = 1'b1;
            repeat (2) cycle();
            kick = 1'b0;
            repeat (5) cycle();
        end
        check_eq("kick_pulse_count", n_kick - base, 3);
        kick = 1'b1;
        n = 0;
        do begin cycle(); n++; end while (kick_pulse !== 1'b1 && n < 10);
        check_eq("kick_latency", n, 3);
        cycle();
        check_eq("kick_width", kick_pulse, 1'b0);
        kick = 1'b0;
        repeat (4) cycle();

        a_n = 1'b0;
        repeat (20) cycle();
        b_n = 1'b0;
        repeat (DISC + 20) cycle();
        check_eq("both_pressed_no_fault", {estop_a, estop_b, disc_fault}, 3'b110);
        a_n = 1'b1;
        b_n = 1'b1;
        repeat (REL + 5) cycle();

        a_n = 1'b0;
        ack_n = 1'b0;
        kick = 1'b1;
        repeat (PRESS + 12) cycle();
        async_reset_check();
        cycle();
        cycle();
        a_n = 1'b1;
        ack_n = 1'b1;
        kick = 1'b0;
        rst_n = 1'b1;
        base = n_ack + n_kick;
        repeat (8) cycle();
        check_eq("no_pulse_after_reset", n_ack + n_kick - base, 0);
        repeat (REL + 5) cycle();

        hold = '{0, 0, 0, 0};
        for (int c = 0; c < 4000; c++) begin
            for (int j = 0; j < 4; j++) begin
                if (hold[j] == 0) begin
                    case (j)
                        0: a_n = ~a_n;
                        1: b_n = ~b_n;
                        2: ack_n = ~ack_n;
                        default: kick = ~kick;
                    endcase
                    hold[j] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, PRESS + 1))
                                                          : int'($urandom_range(1, 8 * REL));
                end else begin
                    hold[j]--;
                end
            end
            if ($urandom_range(0, 999) == 0) begin
                async_reset_check();
                cycle();
                rst_n = 1'b1;
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
